// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map, source count.
package interrupt_controller_pkg;

   localparam int NUM_IRQ = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [1:0] REG_MASK  = 2'd0;
   localparam logic [1:0] REG_PEND  = 2'd1;
   localparam logic [1:0] REG_CAUSE = 2'd2;

endpackage

// File: rtl/irq_priority_enc.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and valid flag.
module irq_priority_enc
   import interrupt_controller_pkg::*;
(
   input  logic [NUM_IRQ-1:0] req,
   output logic [NUM_IRQ-1:0] onehot,
   output logic [1:0]         idx,
   output logic               valid
);

   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = i[1:0];
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Four-source interrupt controller: pending latch, mask, fixed priority, one request at a time.
// Optional macro INTERRUPT_CONTROLLER_SYNC_EN adds a 2-flop input synchronizer.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter logic [NUM_IRQ-1:0] EDGE_MASK  = 4'b1111,
   parameter logic [NUM_IRQ-1:0] MASK_RESET = 4'b0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               int_taken,
   input  logic               rti,
   input  logic               reg_we,
   input  logic [1:0]         reg_addr,
   input  logic [3:0]         reg_wdata,
   output logic [3:0]         reg_rdata,
   output logic [NUM_IRQ-1:0] interrupts,
   output logic               in_service,
   output logic [1:0]         cause
);

   state_t               state, state_n;
   logic [NUM_IRQ-1:0]   irq_s, irq_prev, pending, mask;
   logic [NUM_IRQ-1:0]   set_v, clr_v, win_oh, int_n;
   logic [1:0]           pres_idx, pidx_n, win_idx, cause_n;
   logic                 win_valid, svc_n, take;

`ifdef INTERRUPT_CONTROLLER_SYNC_EN
   logic [NUM_IRQ-1:0] sync1, sync2;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
      end
   end
   assign irq_s = sync2;
`else
   assign irq_s = irq_in;
`endif

   // Edge sources need a fresh rising edge; level sources set every cycle they are high.
   assign set_v = irq_s & (~EDGE_MASK | ~irq_prev);
   assign clr_v = (take ? interrupts : '0) |
                  ((reg_we && reg_addr == REG_PEND) ? reg_wdata : '0);

   irq_priority_enc u_enc (
      .req    (pending & mask),
      .onehot (win_oh),
      .idx    (win_idx),
      .valid  (win_valid)
   );

   always_comb begin
      state_n = state;
      int_n   = interrupts;
      svc_n   = in_service;
      cause_n = cause;
      pidx_n  = pres_idx;
      take    = 1'b0;
      case (state)
         IDLE: if (win_valid) begin
            int_n   = win_oh;
            pidx_n  = win_idx;
            state_n = REQ;
         end
         REQ: if (int_taken) begin
            take    = 1'b1;
            cause_n = pres_idx;
            int_n   = '0;
            svc_n   = 1'b1;
            state_n = SERVICE;
         end else if (!mask[pres_idx]) begin
            int_n   = '0;
            state_n = IDLE;
         end
         SERVICE: if (rti) begin
            svc_n   = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         irq_prev   <= '0;
         pending    <= '0;
         mask       <= MASK_RESET;
         cause      <= '0;
         pres_idx   <= '0;
         interrupts <= '0;
         in_service <= 1'b0;
      end else begin
         state      <= state_n;
         irq_prev   <= irq_s;
         pending    <= (pending & ~clr_v) | set_v;
         cause      <= cause_n;
         pres_idx   <= pidx_n;
         interrupts <= int_n;
         in_service <= svc_n;
         if (reg_we && reg_addr == REG_MASK) mask <= reg_wdata;
      end
   end

   always_comb begin
      case (reg_addr)
         REG_MASK:  reg_rdata = mask;
         REG_PEND:  reg_rdata = pending;
         REG_CAUSE: reg_rdata = {2'b00, cause};
         default:   reg_rdata = '0;
      endcase
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects four external interrupt sources, latches them as pending, applies a software mask and fixed priority, and presents one request at a time to the fetch stage's 4-bit interrupt input.
- Tracks the in-service interrupt until the fetch stage signals return-from-interrupt (rti).
- Exposes a small register interface (mask, pending, cause) for the core's load/store path.
- Sits between the board-level interrupt sources and the fetch unit.

Parameters:
- NUM_IRQ, 4, number of interrupt sources; fixed at 4 to match the fetch interface.
- EDGE_MASK, 4'b1111, per-source trigger type: 1 = rising-edge triggered, 0 = level triggered.
- MASK_RESET, 4'b0000, mask value after reset (1 = enabled).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq_in  input  4  raw interrupt sources; bit 0 has the highest priority.
- int_taken  input  1  single-cycle pulse from fetch: the presented request was accepted and the PC was redirected.
- rti  input  1  single-cycle pulse: the handler has returned.
- reg_we  input  1  register write strobe.
- reg_addr  input  2  register select: 0 = mask, 1 = pending (write-1-to-clear), 2 = cause (read-only).
- reg_wdata  input  4  write data.
- reg_rdata  output  4  combinational read data for reg_addr.
- interrupts  output  4  one-hot request to fetch; all zero when nothing is requested.
- in_service  output  1  high while a handler is executing.
- cause  output  2  index of the most recently taken interrupt.

Behaviour:
- Reset (async, reset low):
  - pending = 0, mask = MASK_RESET, cause = 0.
  - in_service = 0, interrupts = 0, edge-detect history = 0.
  - State = IDLE.
- Edge detection, per bit:
  - EDGE_MASK bit = 1: pending sets on irq_in & ~irq_prev, where irq_prev is irq_in registered one cycle.
  - EDGE_MASK bit = 0: pending sets whenever irq_in is high.
- Pending clear sources:
  - int_taken clears the bit that was presented.
  - A register write to addr 1 clears pending bits where reg_wdata = 1.
  - If set and clear hit the same bit in the same cycle, set wins, so no event is lost.
- Eligible = pending & mask. Winner = lowest-index eligible bit.
- FSM:
  - IDLE: if eligible != 0, register interrupts = onehot(winner) and go to REQ. Request appears one cycle after the pending bit is visible.
  - REQ:
    - interrupts held stable. A higher-priority arrival does not preempt the presented request.
    - On int_taken: cause = presented index, clear that pending bit, interrupts = 0, in_service = 1, go to SERVICE.
    - If the presented bit is masked off (mask write) before int_taken: drop the request, interrupts = 0, return to IDLE. The pending bit is kept.
  - SERVICE:
    - No new requests are presented; no nesting.
    - On rti: in_service = 0, go to IDLE. A new request can appear on the following cycle.
- Simultaneous events:
  - int_taken and rti in the same cycle: int_taken takes priority; rti is ignored in REQ.
  - rti in IDLE or REQ: ignored.
  - int_taken in IDLE or SERVICE: ignored.
- Register writes:
  - Addr 0 writes mask.
  - Addr 1 is W1C on pending.
  - Addr 2 writes are ignored.
- reg_rdata: mask, pending, or {2'b00, cause}; addr 3 reads 0.
- Reset asserted mid-operation returns all state to the reset values immediately, including a request in flight.

Optional Feature:
- Macro: INTERRUPT_CONTROLLER_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchronizer before edge detection. This adds 2 cycles of latency from an irq_in edge to the pending bit; synchronizer flops reset to 0.
- Undefined: irq_in is used directly, with pending set on the cycle after the edge. The caller guarantees synchronous sources.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2.
  - Register address constants: REG_MASK = 0, REG_PEND = 1, REG_CAUSE = 2.
  - NUM_IRQ = 4.
- One natural sub-module: irq_priority_enc, a combinational 4-bit lowest-index one-hot plus 2-bit index encoder with a valid flag.

Test Plan:
- Mask 4'b0101; pulse irq_in[2] → pending[2] = 1, interrupts = 4'b0100 next cycle. Pulse int_taken → cause = 2, in_service = 1, interrupts = 0, pending[2] = 0.
- Mask 4'b1111; pulse irq_in[3] and irq_in[1] together → interrupts = 4'b0010. After int_taken and rti → interrupts = 4'b1000.
- In SERVICE for source 1, pulse irq_in[0] → interrupts stays 0 and pending[0] = 1 until rti; request 4'b0001 appears the cycle after rti.
- In REQ with source 2, write mask = 4'b0000 → interrupts = 0 and state returns to IDLE with pending[2] still 1. Write 4'b0100 to addr 1 → pending = 0.
- Edge source held high for 10 cycles → exactly one pending set. Set EDGE_MASK[0] = 0 and hold irq_in[0] high → pending[0] re-sets after each int_taken.
- Assert reset while in SERVICE → all outputs 0 and mask = MASK_RESET asynchronously, without waiting for clk. With the sync macro defined, irq_in edge to pending takes 3 cycles.
